// File: rtl/carga_instrucciones.sv
// carga_instrucciones: program loader feeding the instruction-memory write port.
//
// Accepts a byte stream over a valid/ready handshake, packs each group of four
// bytes big-endian into a 32-bit word (first byte in [31:24]) and writes the
// words to consecutive word addresses starting at BASE_ADDR. While a load is in
// progress hold_fetch stalls Fase_1 so it never fetches a half-written program.
//
// Optional build macro: CARGA_CHECKSUM_EN
//   Adds a CHK state that takes one extra byte after the last word. If the
//   mod-256 sum of all data bytes plus that byte is nonzero, err is raised.
//   Without the macro, err is tied low.
//
// Ports:
//   clkFase     in   clock, rising edge
//   rstFase     in   asynchronous active-high reset
//   start       in   begin a load (only looked at while idle)
//   word_count  in   number of words to load, latched on start
//   byte_valid  in   byte_data carries a valid byte
//   byte_data   in   stream byte
//   byte_ready  out  loader takes a byte this cycle
//   mem_we      out  instruction memory write strobe
//   mem_addr    out  word address of the write
//   mem_wdata   out  word being written
//   busy        out  high whenever not idle
//   hold_fetch  out  copy of busy, stalls fetch
//   done        out  one-cycle pulse closing a load
//   err         out  checksum error flag, cleared by the next start

module carga_instrucciones #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clkFase,
    input  logic              rstFase,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              hold_fetch,
    output logic              done,
    output logic              err
);

`ifdef CARGA_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StRecv, StWrite, StChk, StDone} state_t;
`else
    typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone} state_t;
`endif

    localparam logic [ADDR_W:0] OneWord = 1;

    state_t            state;
    logic [1:0]        byteCnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   wordsLeft;
    logic [23:0]       shiftReg;   // first three bytes of the word in progress
    logic              byteAccept;

    // byte_ready is a registered copy of "state is RECV or CHK"
    assign byteAccept = byte_valid & byte_ready;
    assign hold_fetch = busy;

`ifdef CARGA_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] chkTotal;
    // kept at 8 bits so the carry out of the mod-256 sum is dropped
    assign chkTotal = sum + byte_data;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clkFase or posedge rstFase) begin
        if (rstFase) begin
            state      <= StIdle;
            byteCnt    <= '0;
            addr       <= '0;
            wordsLeft  <= '0;
            shiftReg   <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CARGA_CHECKSUM_EN
            sum        <= '0;
            err        <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        wordsLeft <= word_count;
                        addr      <= BASE_ADDR;
                        byteCnt   <= '0;
                        shiftReg  <= '0;
                        busy      <= 1'b1;
`ifdef CARGA_CHECKSUM_EN
                        sum       <= '0;
                        err       <= 1'b0;
`endif
                        if (word_count != '0) begin
                            state      <= StRecv;
                            byte_ready <= 1'b1;
                        end else begin
                            state <= StDone;
                            done  <= 1'b1;
                        end
                    end
                end
                StRecv: begin
                    if (byteAccept) begin
`ifdef CARGA_CHECKSUM_EN
                        sum <= sum + byte_data;
`endif
                        if (byteCnt == 2'd3) begin
                            // fourth byte completes the word; write it next cycle
                            mem_wdata  <= {shiftReg, byte_data};
                            mem_addr   <= addr;
                            mem_we     <= 1'b1;
                            byte_ready <= 1'b0;
                            byteCnt    <= '0;
                            state      <= StWrite;
                        end else begin
                            shiftReg <= {shiftReg[15:0], byte_data};
                            byteCnt  <= byteCnt + 2'd1;
                        end
                    end
                end
                StWrite: begin
                    addr      <= addr + 1'b1;   // wraps silently
                    wordsLeft <= wordsLeft - OneWord;
                    if (wordsLeft != OneWord) begin
                        state      <= StRecv;
                        byte_ready <= 1'b1;
                    end else begin
`ifdef CARGA_CHECKSUM_EN
                        state      <= StChk;
                        byte_ready <= 1'b1;
`else
                        state <= StDone;
                        done  <= 1'b1;
`endif
                    end
                end
`ifdef CARGA_CHECKSUM_EN
                StChk: begin
                    if (byteAccept) begin
                        if (chkTotal != 8'h00) begin
                            err <= 1'b1;
                        end
                        byte_ready <= 1'b0;
                        state      <= StDone;
                        done       <= 1'b1;
                    end
                end
`endif
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carga_instrucciones.sv
module tb_carga_instrucciones;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  wordCount = '0;
    logic        byteValid = 1'b0;
    logic [7:0]  byteData = '0;

    // dut A: BASE_ADDR = 0
    logic        aReady, aWe, aBusy, aHold, aDone, aErr;
    logic [7:0]  aAddr;
    logic [31:0] aWdata;
    // dut B: BASE_ADDR = 0xFE, same stimulus
    logic        bReady, bWe, bBusy, bHold, bDone, bErr;
    logic [7:0]  bAddr;
    logic [31:0] bWdata;

    carga_instrucciones #(.ADDR_W(8), .BASE_ADDR(8'h00)) dutA (
        .clkFase(clk), .rstFase(rst), .start(start), .word_count(wordCount),
        .byte_valid(byteValid), .byte_data(byteData), .byte_ready(aReady),
        .mem_we(aWe), .mem_addr(aAddr), .mem_wdata(aWdata), .busy(aBusy),
        .hold_fetch(aHold), .done(aDone), .err(aErr)
    );

    carga_instrucciones #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dutB (
        .clkFase(clk), .rstFase(rst), .start(start), .word_count(wordCount),
        .byte_valid(byteValid), .byte_data(byteData), .byte_ready(bReady),
        .mem_we(bWe), .mem_addr(bAddr), .mem_wdata(bWdata), .busy(bBusy),
        .hold_fetch(bHold), .done(bDone), .err(bErr)
    );

    always #5 clk = ~clk;

    int          nCompared = 0;
    int          nMismatched = 0;
    int          overlap = 0;
    logic [7:0]  chkSum = '0;
    logic [7:0]  qAddrA[$];
    logic [31:0] qDataA[$];
    logic [7:0]  qAddrB[$];
    logic [31:0] qDataB[$];

    // write monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (aWe === 1'b1) begin
            qAddrA.push_back(aAddr);
            qDataA.push_back(aWdata);
            if (aReady !== 1'b0) overlap++;
        end
        if (bWe === 1'b1) begin
            qAddrB.push_back(bAddr);
            qDataB.push_back(bWdata);
        end
    end

    // All tasks are entered and left on a falling edge.
    task automatic drive_start(input logic [8:0] n);
        start = 1'b1;
        wordCount = n;
        chkSum = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        byteValid = 1'b1;
        byteData = b;
        while (aReady !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            nCompared++;
            nMismatched++;
            $display("FAIL send_byte_timeout byte_ready=%b required 1", aReady);
        end else begin
            chkSum = chkSum + b;
        end
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (aDone !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        nCompared++;
        if (aDone !== 1'b1) begin
            nMismatched++;
            $display("FAIL done_timeout done=%b required 1", aDone);
        end
        @(negedge clk);
    endtask

    task automatic finish_load();
`ifdef CARGA_CHECKSUM_EN
        send_byte(8'h00 - chkSum);
`endif
        wait_done();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        nCompared++;
        if ({aReady, aWe, aBusy, aHold, aDone, aErr, aAddr, aWdata} !== '0) begin
            nMismatched++;
            $display("FAIL reset_outputs got %b/%b/%b/%b/%b/%b/%h/%h required all 0",
                     aReady, aWe, aBusy, aHold, aDone, aErr, aAddr, aWdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        qAddrA.delete(); qDataA.delete();
        drive_start(9'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        #1;
        nCompared++;
        if ({aReady, aWe, aBusy, aHold, aDone, aErr, aAddr, aWdata} !== '0) begin
            nMismatched++;
            $display("FAIL midreset_outputs got %b/%b/%b/%b/%b/%b/%h/%h required all 0",
                     aReady, aWe, aBusy, aHold, aDone, aErr, aAddr, aWdata);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        nCompared++;
        if ({aBusy, aReady} !== 2'b00) begin
            nMismatched++;
            $display("FAIL midreset_idle busy/ready=%b%b required 00", aBusy, aReady);
        end
        nCompared++;
        if (qAddrA.size() !== 0) begin
            nMismatched++;
            $display("FAIL midreset_no_write writes=%0d required 0", qAddrA.size());
        end
    endtask

    task automatic test_single_word();
        drive_start(9'd1);
        nCompared++;
        if ({aBusy, aHold} !== 2'b11) begin
            nMismatched++;
            $display("FAIL single_busy busy/hold=%b%b required 11", aBusy, aHold);
        end
        send_word(32'h20080005);
        nCompared++;
        if ({aWe, aReady, aBusy} !== 3'b101) begin
            nMismatched++;
            $display("FAIL single_we we/ready/busy=%b%b%b required 101", aWe, aReady, aBusy);
        end
        nCompared++;
        if (aAddr !== 8'h00) begin
            nMismatched++;
            $display("FAIL single_addr got %h required 00", aAddr);
        end
        nCompared++;
        if (aWdata !== 32'h20080005) begin
            nMismatched++;
            $display("FAIL single_data got %h required 20080005", aWdata);
        end
`ifdef CARGA_CHECKSUM_EN
        send_byte(8'h00 - chkSum);
`else
        @(negedge clk);
`endif
        nCompared++;
        if ({aDone, aBusy, aWe} !== 3'b110) begin
            nMismatched++;
            $display("FAIL single_done done/busy/we=%b%b%b required 110", aDone, aBusy, aWe);
        end
        @(negedge clk);
        nCompared++;
        if ({aDone, aBusy, aHold} !== 3'b000) begin
            nMismatched++;
            $display("FAIL single_idle done/busy/hold=%b%b%b required 000", aDone, aBusy, aHold);
        end
    endtask

    task automatic test_three_words();
        logic [31:0] expData [3];
        expData[0] = 32'hA1A2A3A4;
        expData[1] = 32'hB1B2B3B4;
        expData[2] = 32'hC1C2C3C4;
        qAddrA.delete(); qDataA.delete();
        overlap = 0;
        drive_start(9'd3);
        send_word(expData[0]);
        send_byte(8'hB1);
        send_byte(8'hB2);
        repeat (3) @(negedge clk);
        send_byte(8'hB3);
        send_byte(8'hB4);
        send_word(expData[2]);
        finish_load();
        nCompared++;
        if (qAddrA.size() !== 3) begin
            nMismatched++;
            $display("FAIL three_count writes=%0d required 3", qAddrA.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nCompared++;
                if (qAddrA[i] !== 8'(i) || qDataA[i] !== expData[i]) begin
                    nMismatched++;
                    $display("FAIL three_write%0d got %h:%h required %h:%h",
                             i, qAddrA[i], qDataA[i], 8'(i), expData[i]);
                end
            end
        end
        nCompared++;
        if (overlap !== 0) begin
            nMismatched++;
            $display("FAIL three_ready_in_write count=%0d required 0", overlap);
        end
    endtask

    task automatic test_wrap_ignored_start();
        logic [7:0]  expAddr [3];
        logic [31:0] expData [3];
        expAddr[0] = 8'hFE; expAddr[1] = 8'hFF; expAddr[2] = 8'h00;
        expData[0] = 32'h01020304;
        expData[1] = 32'h05060708;
        expData[2] = 32'h090A0B0C;
        qAddrB.delete(); qDataB.delete();
        drive_start(9'd3);
        send_word(expData[0]);
        // start pulsed through WRITE and RECV with a different count
        start = 1'b1;
        wordCount = 9'd1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        send_word(expData[1]);
        send_word(expData[2]);
        finish_load();
        nCompared++;
        if (qAddrB.size() !== 3) begin
            nMismatched++;
            $display("FAIL wrap_count writes=%0d required 3", qAddrB.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nCompared++;
                if (qAddrB[i] !== expAddr[i] || qDataB[i] !== expData[i]) begin
                    nMismatched++;
                    $display("FAIL wrap_write%0d got %h:%h required %h:%h",
                             i, qAddrB[i], qDataB[i], expAddr[i], expData[i]);
                end
            end
        end
    endtask

    task automatic test_zero_count();
        qAddrA.delete(); qDataA.delete();
        drive_start(9'd0);
        nCompared++;
        if ({aDone, aBusy, aWe, aReady} !== 4'b1100) begin
            nMismatched++;
            $display("FAIL zero_done done/busy/we/ready=%b%b%b%b required 1100",
                     aDone, aBusy, aWe, aReady);
        end
        nCompared++;
        if (aErr !== 1'b0) begin
            nMismatched++;
            $display("FAIL zero_err got %b required 0", aErr);
        end
        @(negedge clk);
        nCompared++;
        if ({aDone, aBusy} !== 2'b00) begin
            nMismatched++;
            $display("FAIL zero_idle done/busy=%b%b required 00", aDone, aBusy);
        end
        nCompared++;
        if (qAddrA.size() !== 0) begin
            nMismatched++;
            $display("FAIL zero_no_write writes=%0d required 0", qAddrA.size());
        end
    endtask

`ifdef CARGA_CHECKSUM_EN
    task automatic test_checksum();
        drive_start(9'd1);
        send_word(32'h01020304);
        send_byte(8'hF6);
        nCompared++;
        if ({aDone, aErr} !== 2'b10) begin
            nMismatched++;
            $display("FAIL chk_good done/err=%b%b required 10", aDone, aErr);
        end
        @(negedge clk);
        drive_start(9'd1);
        send_word(32'h01020304);
        send_byte(8'hF5);
        nCompared++;
        if ({aDone, aErr} !== 2'b11) begin
            nMismatched++;
            $display("FAIL chk_bad done/err=%b%b required 11", aDone, aErr);
        end
        repeat (4) @(negedge clk);
        nCompared++;
        if (aErr !== 1'b1) begin
            nMismatched++;
            $display("FAIL chk_err_hold got %b required 1", aErr);
        end
        drive_start(9'd0);
        nCompared++;
        if (aErr !== 1'b0) begin
            nMismatched++;
            $display("FAIL chk_err_clear got %b required 0", aErr);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_load();
        test_single_word();
        test_three_words();
        test_wrap_ignored_start();
        test_zero_count();
`ifdef CARGA_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
